// File: rtl/psk_pkg.sv
// Shared constants for the PSK receive path: mode encodings, PRBS-7 taps, checker states.
// Latency: n/a (package only).
// Backpressure: n/a.
package psk_pkg;

  // MODE_CTRL encodings (one-hot); any other value means "ignore input".
  localparam logic [3:0] MODE_BPSK = 4'b0001;
  localparam logic [3:0] MODE_QPSK = 4'b0010;
  localparam logic [3:0] MODE_MIX  = 4'b0100;

  // PRBS-7 polynomial x^7 + x^6 + 1: tap positions (1-based).
  localparam int PRBS7_TAP_HI = 7;
  localparam int PRBS7_TAP_LO = 6;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } chk_state_e;

endpackage

// File: rtl/prbs_self_sync.sv
// Self-synchronising PRBS-7 predictor: up to two bits per cycle, first bit chained into the second.
// Latency: err/nbits combinational from the symbol; shift register updates on the next clk edge.
// Backpressure: none, every valid symbol is consumed in its cycle.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset (shift register to 0)
//   sym_vld      symbol present this cycle
//   sym_two      1: two bits, sym_dat[1] first then sym_dat[0]; 0: one bit sym_dat[0]
//   sym_dat      symbol bits
//   nbits        number of bits consumed this cycle (0..2)
//   err          per-bit mismatch against prediction, err[0] = first bit
module prbs_self_sync
  import psk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sym_vld,
  input  logic       sym_two,
  input  logic [1:0] sym_dat,
  output logic [1:0] nbits,
  output logic [1:0] err
);

  logic [6:0] sr_q, sr_d;
  logic [6:0] sr_mid;
  logic       b0, b1;

  always_comb begin
    b0     = sym_two ? sym_dat[1] : sym_dat[0];
    b1     = sym_dat[0];
    // Shift register after the first bit, used to predict the second bit.
    sr_mid = {sr_q[5:0], b0};
    sr_d   = sr_q;
    nbits  = 2'd0;
    err    = 2'b00;
    if (sym_vld) begin
      err[0] = b0 ^ sr_q[PRBS7_TAP_HI-1] ^ sr_q[PRBS7_TAP_LO-1];
      nbits  = 2'd1;
      sr_d   = sr_mid;
      if (sym_two) begin
        err[1] = b1 ^ sr_mid[PRBS7_TAP_HI-1] ^ sr_mid[PRBS7_TAP_LO-1];
        nbits  = 2'd2;
        sr_d   = {sr_mid[5:0], b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/rx_prbs_checker.sv
// Rx byte-stream sink: PRBS-7 lock search, loss-of-lock windows, saturating BER/frame statistics.
// Latency: locked and all counters update on the clock edge after the tvalid cycle (1 cycle).
// Backpressure: none, input is a one-cycle strobe and is always accepted.
//
// Ports:
//   clk_32M768, rst_32M768   clock, synchronous active-high reset
//   clr                      clears counters and frame flag (FSM and shift register kept)
//   MODE_CTRL                BPSK forces 1 bit, QPSK forces 2 bits, MIX follows tuser, else ignore
//   data_tdata/tvalid/tlast/tuser   symbol stream ([1:0] bits, tuser=1 -> 2 bits)
//   locked, bit_cnt, err_cnt, frame_cnt, frame_err_cnt   status and statistics
//   frame_done, frame_err    one-cycle frame-end pulse and its error flag
module rx_prbs_checker
  import psk_pkg::*;
#(
  parameter int PRBS_LEN = 7,
  parameter int LOCK_CNT = 32,
  parameter int LOSS_WIN = 64,
  parameter int LOSS_THR = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk_32M768,
  input  logic             rst_32M768,
  input  logic             clr,
  input  logic [3:0]       MODE_CTRL,
  input  logic [7:0]       data_tdata,
  input  logic             data_tvalid,
  input  logic             data_tlast,
  input  logic             data_tuser,
  output logic             locked,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      frame_err_cnt,
  output logic             frame_done,
  output logic             frame_err
);

  localparam int FILL_W = $clog2(PRBS_LEN + 1);
  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int WIN_W  = $clog2(LOSS_WIN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PRBS_LEN);
  localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_CNT);
  localparam logic [WIN_W-1:0]  WIN_END   = WIN_W'(LOSS_WIN);
  localparam logic [WIN_W-1:0]  WIN_THR   = WIN_W'(LOSS_THR);

  chk_state_e        state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [WIN_W-1:0]  wbits_q, wbits_d;
  logic [WIN_W-1:0]  werrs_q, werrs_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [15:0]       frame_err_cnt_q, frame_err_cnt_d;
  logic              flag_q, flag_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;

  logic              sym_vld, sym_two;
  logic [1:0]        nbits, err;
  logic [1:0]        nscored, nerr;
  logic              flag_nxt;
  logic [CNT_W:0]    bit_sum, err_sum;
  logic              unused_tdata;

  assign unused_tdata = ^data_tdata[7:2];

  assign sym_vld = data_tvalid &&
                   (MODE_CTRL == MODE_BPSK || MODE_CTRL == MODE_QPSK || MODE_CTRL == MODE_MIX);
  assign sym_two = (MODE_CTRL == MODE_QPSK) || (MODE_CTRL == MODE_MIX && data_tuser);

  prbs_self_sync u_sync (
    .clk     (clk_32M768),
    .rst     (rst_32M768),
    .sym_vld (sym_vld),
    .sym_two (sym_two),
    .sym_dat (data_tdata[1:0]),
    .nbits   (nbits),
    .err     (err)
  );

  // Lock/loss FSM, walked once per bit so a state change on the first bit of a
  // 2-bit symbol already governs how the second bit is treated.
  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    run_d    = run_q;
    wbits_d  = wbits_q;
    werrs_d  = werrs_q;
    nscored  = 2'd0;
    nerr     = 2'd0;
    flag_nxt = flag_q;
    for (int i = 0; i < 2; i++) begin
      if (i < int'(nbits)) begin
        if (state_d == ST_SEARCH) begin
          if (fill_d != FILL_FULL) begin
            fill_d = fill_d + FILL_W'(1);
          end else if (err[i]) begin
            run_d = '0;
          end else begin
            run_d = run_d + RUN_W'(1);
            // The bit that completes the run is not itself scored.
            if (run_d == RUN_LOCK) begin
              state_d = ST_LOCKED;
              run_d   = '0;
            end
          end
        end else begin
          nscored = nscored + 2'd1;
          wbits_d = wbits_d + WIN_W'(1);
          if (err[i]) begin
            nerr     = nerr + 2'd1;
            werrs_d  = werrs_d + WIN_W'(1);
            flag_nxt = 1'b1;
          end
          if (wbits_d == WIN_END) begin
            // Shift register is kept on loss; only the fill/run bookkeeping restarts.
            if (werrs_d >= WIN_THR) begin
              state_d = ST_SEARCH;
              fill_d  = '0;
              run_d   = '0;
            end
            wbits_d = '0;
            werrs_d = '0;
          end
        end
      end
    end
  end

  // Statistics and frame tracking.
  always_comb begin
    bit_sum         = {1'b0, bit_cnt_q} + (CNT_W+1)'(nscored);
    err_sum         = {1'b0, err_cnt_q} + (CNT_W+1)'(nerr);
    bit_cnt_d       = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
    err_cnt_d       = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    frame_cnt_d     = frame_cnt_q;
    frame_err_cnt_d = frame_err_cnt_q;
    flag_d          = flag_nxt;
    frame_done_d    = 1'b0;
    frame_err_d     = 1'b0;
    if (sym_vld && data_tlast) begin
      // A frame end is reported when the checker was LOCKED as the last symbol arrived.
      if (state_q == ST_LOCKED) begin
        frame_done_d = 1'b1;
        frame_err_d  = flag_nxt;
        if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 16'd1;
        if (flag_nxt && frame_err_cnt_q != '1) frame_err_cnt_d = frame_err_cnt_q + 16'd1;
      end
      flag_d = 1'b0;
    end
    if (clr) begin
      bit_cnt_d       = '0;
      err_cnt_d       = '0;
      frame_cnt_d     = '0;
      frame_err_cnt_d = '0;
      flag_d          = 1'b0;
    end
  end

  always_ff @(posedge clk_32M768) begin
    if (rst_32M768) begin
      state_q         <= ST_SEARCH;
      fill_q          <= '0;
      run_q           <= '0;
      wbits_q         <= '0;
      werrs_q         <= '0;
      bit_cnt_q       <= '0;
      err_cnt_q       <= '0;
      frame_cnt_q     <= '0;
      frame_err_cnt_q <= '0;
      flag_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      fill_q          <= fill_d;
      run_q           <= run_d;
      wbits_q         <= wbits_d;
      werrs_q         <= werrs_d;
      bit_cnt_q       <= bit_cnt_d;
      err_cnt_q       <= err_cnt_d;
      frame_cnt_q     <= frame_cnt_d;
      frame_err_cnt_q <= frame_err_cnt_d;
      flag_q          <= flag_d;
      frame_done_q    <= frame_done_d;
      frame_err_q     <= frame_err_d;
    end
  end

  assign locked        = (state_q == ST_LOCKED);
  assign bit_cnt       = bit_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign frame_cnt     = frame_cnt_q;
  assign frame_err_cnt = frame_err_cnt_q;
  assign frame_done    = frame_done_q;
  assign frame_err     = frame_err_q;

endmodule
